// File: rtl/uart_rx_fifo.sv
`timescale 1ns / 1ps
// 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Framing errors and dropped bytes are reported as registered one-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned BAUD  = 115200,
    parameter int unsigned FREQ  = 50000000,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_i,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     frame_err_o,
    output logic                     overflow_o
);

    localparam int unsigned Cps  = FREQ / BAUD;
    localparam int unsigned CntW = $clog2(Cps);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;

    localparam logic [CntW-1:0] CntHalf = CntW'(Cps / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(Cps - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              rx_meta_q, rx_s_q;
    logic              push, ferr;

    logic [7:0]        mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              frame_err_q, overflow_q;
    logic              pop, full, wr_en;

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr    = 1'b1;
                        state_d = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign pop   = (level_q != '0) && ready_i;
    assign full  = (level_q == LW'(DEPTH));
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_en && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !wr_en) begin
                level_q <= level_q - LW'(1);
            end
            frame_err_q <= ferr;
            overflow_q  <= push && full && !pop;
        end
    end

    assign data_o      = mem_q[rd_ptr_q];
    assign valid_o     = (level_q != '0);
    assign level_o     = level_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns / 1ps
// Directed bench for uart_rx_fifo at CPS=8: normal frames, back-pressure,
// overflow, glitch rejection, framing error/break and mid-frame reset.
module tb_uart_rx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] level_o;
    logic       frame_err_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         v_cnt  = 0;
    int         pop_n  = 0;
    logic [7:0] pop_log [256];

    int base_fe, base_ov, base_v, base_pop;

    uart_rx_fifo #(
        .BAUD  (125000),
        .FREQ  (1000000),
        .DEPTH (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (frame_err_o) fe_cnt <= fe_cnt + 1;
        if (overflow_o) ov_cnt <= ov_cnt + 1;
        if (valid_o) v_cnt <= v_cnt + 1;
        if (valid_o && ready_i) begin
            pop_log[pop_n[7:0]] <= data_o;
            pop_n               <= pop_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        base_fe  = fe_cnt;
        base_ov  = ov_cnt;
        base_v   = v_cnt;
        base_pop = pop_n;
    endtask

    // Called at a negedge; optionally raises ready_i for the stop-sample cycle.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic rdy_pulse);
        rx_i = 1'b0;
        repeat (8) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (8) @(negedge clk_i);
        end
        rx_i = stop_bit;
        for (int i = 0; i < 8; i++) begin
            if (rdy_pulse) ready_i = (i == 6);
            @(negedge clk_i);
        end
        if (rdy_pulse) ready_i = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_level", 32'(level_o), 32'd0);
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_ferr", 32'(frame_err_o), 32'd0);
        check("reset_ovf", 32'(overflow_o), 32'd0);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);

        // Single byte, consumer always ready.
        snap();
        ready_i = 1'b1;
        send_byte(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("a5_pops", 32'(pop_n - base_pop), 32'd1);
        check("a5_data", 32'(pop_log[base_pop[7:0]]), 32'hA5);
        check("a5_valid_cycles", 32'(v_cnt - base_v), 32'd1);
        check("a5_level", 32'(level_o), 32'd0);
        check("a5_ferr", 32'(fe_cnt - base_fe), 32'd0);
        check("a5_ovf", 32'(ov_cnt - base_ov), 32'd0);

        // Three back-to-back bytes with back-pressure.
        snap();
        ready_i = 1'b0;
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("b2b_level", 32'(level_o), 32'd3);
        check("b2b_head", 32'(data_o), 32'h00);
        check("b2b_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        repeat (6) @(negedge clk_i);
        ready_i = 1'b0;
        check("b2b_pops", 32'(pop_n - base_pop), 32'd3);
        check("b2b_pop0", 32'(pop_log[8'(base_pop)]), 32'h00);
        check("b2b_pop1", 32'(pop_log[8'(base_pop + 1)]), 32'hFF);
        check("b2b_pop2", 32'(pop_log[8'(base_pop + 2)]), 32'h5A);
        check("b2b_level_end", 32'(level_o), 32'd0);

        // Nine bytes into an 8-deep FIFO.
        snap();
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("ovf_level", 32'(level_o), 32'd8);
        check("ovf_pulses", 32'(ov_cnt - base_ov), 32'd1);
        check("ovf_head", 32'(data_o), 32'h01);
        ready_i = 1'b1;
        repeat (12) @(negedge clk_i);
        ready_i = 1'b0;
        check("ovf_drain_pops", 32'(pop_n - base_pop), 32'd8);
        check("ovf_drain_last", 32'(pop_log[8'(base_pop + 7)]), 32'h08);

        // Same, but a pop coincides with the ninth push.
        snap();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b0);
        send_byte(8'h09, 1'b1, 1'b1);
        repeat (4) @(negedge clk_i);
        check("full_pp_level", 32'(level_o), 32'd8);
        check("full_pp_ovf", 32'(ov_cnt - base_ov), 32'd0);
        check("full_pp_head", 32'(data_o), 32'h02);
        ready_i = 1'b1;
        repeat (12) @(negedge clk_i);
        ready_i = 1'b0;
        check("full_pp_pops", 32'(pop_n - base_pop), 32'd9);
        check("full_pp_first", 32'(pop_log[8'(base_pop)]), 32'h01);
        check("full_pp_last", 32'(pop_log[8'(base_pop + 8)]), 32'h09);

        // Short low glitch is rejected.
        snap();
        rx_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("glitch_level", 32'(level_o), 32'd0);
        check("glitch_ferr", 32'(fe_cnt - base_fe), 32'd0);
        check("glitch_state", 32'(int'(dut.state_q)), 32'd0);

        // Bad stop bit followed by a held-low line.
        snap();
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("brk_ferr", 32'(fe_cnt - base_fe), 32'd1);
        check("brk_level", 32'(level_o), 32'd0);
        send_byte(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("brk_recover_data", 32'(data_o), 32'h3C);
        check("brk_recover_level", 32'(level_o), 32'd1);
        check("brk_recover_ferr", 32'(fe_cnt - base_fe), 32'd1);

        // Reset during bit 4 of a frame with two more bytes queued.
        send_byte(8'h11, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("rst_pre_level", 32'(level_o), 32'd2);
        snap();
        rx_i = 1'b0;
        repeat (8) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            rx_i = (i == 1 || i == 3);
            repeat (8) @(negedge clk_i);
        end
        rx_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        rx_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("rst_no_pulse", 32'((fe_cnt - base_fe) + (ov_cnt - base_ov)), 32'd0);
        send_byte(8'h77, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("rst_fresh_data", 32'(data_o), 32'h77);
        check("rst_fresh_level", 32'(level_o), 32'd1);
        check("rst_fresh_ferr", 32'(fe_cnt - base_fe), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
